// File: rtl/enc8b10b_pkg.sv
// Shared 8B/10B link definitions: the K-characters the scheduler frames with,
// the scheduler state encoding, and the channel-to-SOP mapping.
package enc8b10b_pkg;

  // Special characters, sent with the K flag set.
  localparam logic [7:0] K28_5 = 8'hBC;  // idle fill and comma
  localparam logic [7:0] K27_7 = 8'hFB;  // start of packet, channel 0
  localparam logic [7:0] K28_2 = 8'h5C;  // start of packet, channel 1
  localparam logic [7:0] K29_7 = 8'hFD;  // end of packet

  typedef enum logic [1:0] {
    ST_ALIGN,
    ST_IDLE,
    ST_PAYLOAD,
    ST_EOP
  } link_state_e;

  // One character as seen by the encoder.
  typedef struct packed {
    logic       k;
    logic [7:0] data;
  } tx_char_t;

  // Each channel has its own start-of-packet code so the far end can
  // demultiplex without any side band.
  function automatic logic [7:0] sop_code(input logic ch);
    return ch ? K28_2 : K27_7;
  endfunction

endpackage

// File: rtl/tx_rr_arbiter.sv
// Two-way round-robin arbiter. Purely combinational: the caller holds the
// previous grant and decides when a new decision is committed.
module tx_rr_arbiter (
  input  logic [1:0] req,
  input  logic       prev_grant,
  output logic       grant,
  output logic       any_req
);

  // Contention goes to the channel that did not win last time; a lone
  // requester always wins.
  always_comb begin
    // NOTE: every output gets a default before the branches, so no path
    // leaves a value unassigned and no latch can be inferred.
    any_req = |req;
    grant   = prev_grant;
    if (req == 2'b11) begin
      grant = ~prev_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end else if (req[0]) begin
      grant = 1'b0;
    end
  end

endmodule

// File: rtl/tx_link_sched.sv
// Transmit link scheduler in front of the 8B/10B encoder. Multiplexes two
// byte-stream channels onto one character-per-clock link, frames packets
// with SOP/EOP K-characters, and keeps the far-end decoder aligned with an
// initial comma burst, K28.5 idle fill and forced periodic commas.
module tx_link_sched
  import enc8b10b_pkg::*;
#(
  parameter int ALIGN_CNT      = 16,
  parameter int COMMA_INTERVAL = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic [1:0]  ch_valid,
  input  logic [15:0] ch_data,
  input  logic [1:0]  ch_last,
  output logic [1:0]  ch_ready,
  output logic [7:0]  tx_data,
  output logic        tx_k,
  output logic        busy,
  output logic        grant
);

  localparam int ALIGN_W = $clog2(ALIGN_CNT + 1);
  localparam int RUN_W   = $clog2(COMMA_INTERVAL + 1);

  localparam logic [ALIGN_W-1:0] ALIGN_LOAD = ALIGN_W'(ALIGN_CNT);
  localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(COMMA_INTERVAL);

  // Registered state.
  link_state_e        state;
  logic [ALIGN_W-1:0] align_cnt;
  logic [RUN_W-1:0]   run_cnt;

  // Next-state decisions.
  link_state_e        nxt_state;
  logic [ALIGN_W-1:0] nxt_align;
  logic               nxt_grant;
  tx_char_t           nxt_char;
  logic               nxt_is_comma;

  // Arbiter view of the requesters.
  logic               arb_grant;
  logic               any_req;
  logic               comma_due;
  logic               grant_valid;
  logic               grant_last;
  logic [7:0]         grant_data;

  // The run counter reaching its limit means the link has carried the
  // longest allowed stretch without a comma; the next character must be one.
  assign comma_due = (run_cnt == RUN_MAX);

  // Byte presented by the channel that owns the current packet.
  assign grant_valid = ch_valid[grant];
  assign grant_last  = ch_last[grant];
  assign grant_data  = grant ? ch_data[15:8] : ch_data[7:0];

  tx_rr_arbiter u_arb (
    .req        (ch_valid),
    .prev_grant (grant),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  // Ready depends only on state and counters so a source may wait for ready
  // before raising valid without forming a combinational loop.
  always_comb begin
    ch_ready = 2'b00;
    if (state == ST_PAYLOAD && !comma_due) begin
      ch_ready = grant ? 2'b10 : 2'b01;
    end
  end

  // Packet framing is in progress from the first payload slot until EOP
  // has gone out.
  assign busy = (state == ST_PAYLOAD) || (state == ST_EOP);

  // Choose the next character and state; a due comma freezes everything.
  always_comb begin
    nxt_char.k    = 1'b1;
    nxt_char.data = K28_5;
    nxt_state     = state;
    nxt_align     = align_cnt;
    nxt_grant     = grant;
    if (!comma_due) begin
      case (state)
        ST_ALIGN: begin
          nxt_align = align_cnt - ALIGN_W'(1);
          if (align_cnt == ALIGN_W'(1)) begin
            nxt_state = ST_IDLE;
          end
        end
        ST_IDLE: begin
          // tx_en gates only the start of a packet.
          if (tx_en && any_req) begin
            nxt_char.data = sop_code(arb_grant);
            nxt_grant     = arb_grant;
            nxt_state     = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          // An empty source is covered with K28.5 filler, packet stays open.
          if (grant_valid) begin
            nxt_char.k    = 1'b0;
            nxt_char.data = grant_data;
            if (grant_last) begin
              nxt_state = ST_EOP;
            end
          end
        end
        ST_EOP: begin
          nxt_char.data = K29_7;
          nxt_state     = ST_IDLE;
        end
        default: begin
          nxt_state = ST_ALIGN;
        end
      endcase
    end
    // Data bytes equal to 8'hBC are not commas; only the K-character counts.
    nxt_is_comma = nxt_char.k && (nxt_char.data == K28_5);
  end

  // State, counters and the link character all update on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    if (!rst_n) begin
      // NOTE: the output character is reset too, so the encoder sees a clean
      // comma the instant reset asserts and a mid-packet abort sends no EOP.
      state     <= ST_ALIGN;
      align_cnt <= ALIGN_LOAD;
      run_cnt   <= '0;
      tx_data   <= K28_5;
      tx_k      <= 1'b1;
      grant     <= 1'b1;
    end else begin
      state     <= nxt_state;
      align_cnt <= nxt_align;
      grant     <= nxt_grant;
      tx_data   <= nxt_char.data;
      tx_k      <= nxt_char.k;
      if (nxt_is_comma) begin
        run_cnt <= '0;
      end else if (run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_link_sched.sv
// Self-checking bench for tx_link_sched. Two instances: one at the default
// comma interval, one with a short interval to exercise forced commas.
module tb_tx_link_sched;

  localparam logic [7:0] C_COMMA = 8'hBC;
  localparam logic [7:0] C_SOP0  = 8'hFB;
  localparam logic [7:0] C_SOP1  = 8'h5C;
  localparam logic [7:0] C_EOP   = 8'hFD;
  localparam logic [8:0] K_COMMA = {1'b1, C_COMMA};
  localparam logic [8:0] K_SOP0  = {1'b1, C_SOP0};
  localparam logic [8:0] K_SOP1  = {1'b1, C_SOP1};
  localparam logic [8:0] K_EOP   = {1'b1, C_EOP};
  localparam int ALIGN    = 16;
  localparam int CI_MAIN  = 256;
  localparam int CI_SHORT = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        tx_en = 1'b1;
  logic [1:0]  ch_valid, ch_last, ch_ready;
  logic [15:0] ch_data;
  logic [7:0]  tx_data;
  logic        tx_k, busy, grant;
  logic [1:0]  ci_valid, ci_last, ci_ready;
  logic [15:0] ci_data;
  logic [7:0]  ci_tx_data;
  logic        ci_tx_k, ci_busy, ci_grant;

  int n_checks = 0;
  int n_errors = 0;

  // Source queues: {last, byte}; logs of the link and pre-edge ready.
  logic [8:0] src0[$], src1[$], ci_src0[$], ci_src1[$];
  logic [1:0] vmask = 2'b11;
  logic [8:0] link_q[$], ci_link_q[$];
  logic [1:0] rdy_q[$], ci_rdy_q[$];
  logic       grant_q[$];
  int         acc_cnt[2];

  // Abstract link model: counters and flags, no state encoding.
  typedef struct {
    int align_left;
    bit in_pkt;
    bit eop_pend;
    int owner;
    int since;
  } model_t;

  always #5 clk = ~clk;

  tx_link_sched #(.ALIGN_CNT(ALIGN), .COMMA_INTERVAL(CI_MAIN)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .ch_valid(ch_valid),
    .ch_data(ch_data), .ch_last(ch_last), .ch_ready(ch_ready),
    .tx_data(tx_data), .tx_k(tx_k), .busy(busy), .grant(grant)
  );

  tx_link_sched #(.ALIGN_CNT(ALIGN), .COMMA_INTERVAL(CI_SHORT)) dut_ci (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .ch_valid(ci_valid),
    .ch_data(ci_data), .ch_last(ci_last), .ch_ready(ci_ready),
    .tx_data(ci_tx_data), .tx_k(ci_tx_k), .busy(ci_busy), .grant(ci_grant)
  );

  function automatic logic [8:0] at(input logic [8:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 9'bx;
  endfunction

  task automatic drive_inputs();
    logic [8:0] h0, h1, c0, c1;
    h0 = (src0.size() > 0) ? src0[0] : 9'h000;
    h1 = (src1.size() > 0) ? src1[0] : 9'h000;
    c0 = (ci_src0.size() > 0) ? ci_src0[0] : 9'h000;
    c1 = (ci_src1.size() > 0) ? ci_src1[0] : 9'h000;
    ch_valid = {(src1.size() > 0) && vmask[1], (src0.size() > 0) && vmask[0]};
    ch_data  = {h1[7:0], h0[7:0]};
    ch_last  = {h1[8], h0[8]};
    ci_valid = {(ci_src1.size() > 0) && vmask[1], (ci_src0.size() > 0) && vmask[0]};
    ci_data  = {c1[7:0], c0[7:0]};
    ci_last  = {c1[8], c0[8]};
  endtask

  task automatic pop_accepted(input logic [1:0] acc, input logic [1:0] ci_acc);
    if (acc[0]) begin void'(src0.pop_front()); acc_cnt[0]++; end
    if (acc[1]) begin void'(src1.pop_front()); acc_cnt[1]++; end
    if (ci_acc[0]) void'(ci_src0.pop_front());
    if (ci_acc[1]) void'(ci_src1.pop_front());
  endtask

  // One clock: drive, sample ready before the edge, log the link after it.
  task automatic tick();
    logic [1:0] acc, ci_acc;
    drive_inputs();
    #1;
    acc    = ch_valid & ch_ready;
    ci_acc = ci_valid & ci_ready;
    rdy_q.push_back(ch_ready);
    ci_rdy_q.push_back(ci_ready);
    @(posedge clk);
    pop_accepted(acc, ci_acc);
    #1;
    link_q.push_back({tx_k, tx_data});
    ci_link_q.push_back({ci_tx_k, ci_tx_data});
    grant_q.push_back(grant);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src0.delete(); src1.delete(); ci_src0.delete(); ci_src1.delete();
    link_q.delete(); ci_link_q.delete(); rdy_q.delete(); ci_rdy_q.delete();
    grant_q.delete();
    acc_cnt = '{0, 0};
    vmask   = 2'b11;
    tx_en   = 1'b1;
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_step(inout model_t m, input int ci, input logic en,
                            input logic [1:0] v, input logic [15:0] d,
                            input logic [1:0] l, output logic [8:0] chr,
                            output logic [1:0] rdy);
    int w;
    rdy = 2'b00;
    chr = K_COMMA;
    if (m.since >= ci) begin
      chr = K_COMMA;
    end else if (m.align_left > 0) begin
      m.align_left--;
    end else if (m.eop_pend) begin
      chr = K_EOP;
      m.eop_pend = 1'b0;
    end else if (m.in_pkt) begin
      rdy[m.owner] = 1'b1;
      if (v[m.owner]) begin
        chr = {1'b0, d[8*m.owner +: 8]};
        if (l[m.owner]) begin
          m.in_pkt   = 1'b0;
          m.eop_pend = 1'b1;
        end
      end
    end else if (en && v != 2'b00) begin
      if (v == 2'b11) w = 1 - m.owner;
      else w = v[1] ? 1 : 0;
      chr      = (w == 0) ? K_SOP0 : K_SOP1;
      m.owner  = w;
      m.in_pkt = 1'b1;
    end
    if (chr == K_COMMA) m.since = 0;
    else if (m.since < ci) m.since++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_inputs();
    #2;
    n_checks++;
    if ({tx_k, tx_data} !== K_COMMA) begin
      n_errors++; $display("FAIL reset_char: got %h expected %h", {tx_k, tx_data}, K_COMMA);
    end
    n_checks++;
    if (ch_ready !== 2'b00) begin
      n_errors++; $display("FAIL reset_ready: got %b expected 00", ch_ready);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    n_checks++;
    if (grant !== 1'b1) begin
      n_errors++; $display("FAIL reset_grant: got %b expected 1", grant);
    end
    do_reset();
    repeat (ALIGN + 8) tick();
    for (int i = 0; i < ALIGN + 8; i++) begin
      n_checks++;
      if (at(link_q, i) !== K_COMMA) begin
        n_errors++; $display("FAIL align_char[%0d]: got %h expected %h", i, at(link_q, i), K_COMMA);
      end
      n_checks++;
      if (rdy_q[i] !== 2'b00) begin
        n_errors++; $display("FAIL align_ready[%0d]: got %b expected 00", i, rdy_q[i]);
      end
    end
  endtask

  task automatic test_single_packet();
    logic [8:0] exp_q[$];
    do_reset();
    src0 = '{9'h011, 9'h022, 9'h133};
    repeat (ALIGN + 6) tick();
    for (int i = 0; i < ALIGN; i++) exp_q.push_back(K_COMMA);
    exp_q.push_back(K_SOP0);
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h022);
    exp_q.push_back(9'h033);
    exp_q.push_back(K_EOP);
    exp_q.push_back(K_COMMA);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (at(link_q, i) !== exp_q[i]) begin
        n_errors++; $display("FAIL single_link[%0d]: got %h expected %h", i, at(link_q, i), exp_q[i]);
      end
    end
    n_checks++;
    if (acc_cnt[0] !== 3) begin
      n_errors++; $display("FAIL single_handshakes: got %0d expected 3", acc_cnt[0]);
    end
    n_checks++;
    if (grant_q[ALIGN] !== 1'b0) begin
      n_errors++; $display("FAIL single_grant: got %b expected 0", grant_q[ALIGN]);
    end
  endtask

  task automatic test_round_robin();
    int sops[$];
    logic gnts[$];
    int cur, bad, ndata;
    logic [8:0] c;
    do_reset();
    src0 = '{9'h010, 9'h111, 9'h012, 9'h113};
    src1 = '{9'h020, 9'h121, 9'h022, 9'h123};
    for (int i = 0; i < 80 && (src0.size() > 0 || src1.size() > 0); i++) tick();
    repeat (3) tick();
    n_checks++;
    if (src0.size() + src1.size() !== 0) begin
      n_errors++; $display("FAIL rr_drain: got %0d bytes left expected 0", src0.size() + src1.size());
    end
    cur = -1; bad = 0; ndata = 0;
    for (int i = 0; i < link_q.size(); i++) begin
      c = link_q[i];
      if (c == K_SOP0) begin
        sops.push_back(0); gnts.push_back(grant_q[i]); cur = 0;
      end else if (c == K_SOP1) begin
        sops.push_back(1); gnts.push_back(grant_q[i]); cur = 1;
      end else if (c == K_EOP) begin
        cur = -1;
      end else if (!c[8]) begin
        ndata++;
        if (cur < 0 || c[7:4] != ((cur == 0) ? 4'h1 : 4'h2)) bad++;
      end
    end
    n_checks++;
    if (sops.size() !== 4) begin
      n_errors++; $display("FAIL rr_sop_count: got %0d expected 4", sops.size());
    end
    for (int j = 0; j < sops.size(); j++) begin
      n_checks++;
      if (sops[j] !== j % 2) begin
        n_errors++; $display("FAIL rr_sop[%0d]: got ch%0d expected ch%0d", j, sops[j], j % 2);
      end
      n_checks++;
      if (gnts[j] !== 1'((j % 2))) begin
        n_errors++; $display("FAIL rr_grant[%0d]: got %b expected %0d", j, gnts[j], j % 2);
      end
    end
    n_checks++;
    if (bad !== 0 || ndata !== 8) begin
      n_errors++; $display("FAIL rr_ownership: got %0d misplaced of %0d bytes expected 0 of 8", bad, ndata);
    end
  endtask

  task automatic test_comma_insert();
    logic [8:0] exp_ci[$], exp_main[$];
    do_reset();
    ci_src1 = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h106};
    src1    = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h106};
    repeat (ALIGN + 10) tick();
    for (int i = 0; i < ALIGN; i++) begin
      exp_ci.push_back(K_COMMA); exp_main.push_back(K_COMMA);
    end
    exp_ci = {exp_ci, K_SOP1, 9'h001, 9'h002, 9'h003, K_COMMA, 9'h004, 9'h005, 9'h006, K_EOP, K_COMMA};
    exp_main = {exp_main, K_SOP1, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, K_EOP, K_COMMA, K_COMMA};
    for (int i = 0; i < exp_ci.size(); i++) begin
      n_checks++;
      if (at(ci_link_q, i) !== exp_ci[i]) begin
        n_errors++; $display("FAIL comma_link[%0d]: got %h expected %h", i, at(ci_link_q, i), exp_ci[i]);
      end
      n_checks++;
      if (at(link_q, i) !== exp_main[i]) begin
        n_errors++; $display("FAIL nocomma_link[%0d]: got %h expected %h", i, at(link_q, i), exp_main[i]);
      end
    end
    n_checks++;
    if (ci_rdy_q[ALIGN + 4] !== 2'b00) begin
      n_errors++; $display("FAIL comma_ready: got %b expected 00", ci_rdy_q[ALIGN + 4]);
    end
    n_checks++;
    if (ci_rdy_q[ALIGN + 5] !== 2'b10) begin
      n_errors++; $display("FAIL comma_ready_after: got %b expected 10", ci_rdy_q[ALIGN + 5]);
    end
  endtask

  task automatic test_underflow();
    logic [8:0] exp_q[$];
    do_reset();
    src0 = '{9'h0A1, 9'h0A2, 9'h1A3};
    for (int i = 0; i < 40 && acc_cnt[0] == 0; i++) tick();
    vmask = 2'b10;
    repeat (2) tick();
    vmask = 2'b11;
    repeat (5) tick();
    exp_q = '{K_SOP0, 9'h0A1, K_COMMA, K_COMMA, 9'h0A2, 9'h0A3, K_EOP, K_COMMA};
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (at(link_q, ALIGN + i) !== exp_q[i]) begin
        n_errors++; $display("FAIL underflow_link[%0d]: got %h expected %h", i, at(link_q, ALIGN + i), exp_q[i]);
      end
    end
    n_checks++;
    if (acc_cnt[0] !== 3) begin
      n_errors++; $display("FAIL underflow_handshakes: got %0d expected 3", acc_cnt[0]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    src0 = '{9'h0B0, 9'h0B1, 9'h0B2, 9'h0B3, 9'h0B4, 9'h1B5};
    for (int i = 0; i < 40 && acc_cnt[0] < 2; i++) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_k, tx_data} !== K_COMMA) begin
      n_errors++; $display("FAIL midrst_char: got %h expected %h", {tx_k, tx_data}, K_COMMA);
    end
    n_checks++;
    if (busy !== 1'b0 || ch_ready !== 2'b00) begin
      n_errors++; $display("FAIL midrst_busy_ready: got %b/%b expected 0/00", busy, ch_ready);
    end
    n_checks++;
    if (grant !== 1'b1) begin
      n_errors++; $display("FAIL midrst_grant: got %b expected 1", grant);
    end
    do_reset();
    src1 = '{9'h1C1};
    repeat (ALIGN + 4) tick();
    for (int i = 0; i < ALIGN; i++) begin
      n_checks++;
      if (at(link_q, i) !== K_COMMA) begin
        n_errors++; $display("FAIL midrst_align[%0d]: got %h expected %h", i, at(link_q, i), K_COMMA);
      end
    end
    n_checks++;
    if (at(link_q, ALIGN) !== K_SOP1) begin
      n_errors++; $display("FAIL midrst_sop: got %h expected %h", at(link_q, ALIGN), K_SOP1);
    end
  endtask

  task automatic push_pkt(input int ch, input bit short_dut);
    int len;
    logic [8:0] b;
    len = int'($urandom_range(1, 6));
    for (int i = 0; i < len; i++) begin
      b = {(i == len - 1), 8'($urandom)};
      if (short_dut) begin
        if (ch == 0) ci_src0.push_back(b); else ci_src1.push_back(b);
      end else begin
        if (ch == 0) src0.push_back(b); else src1.push_back(b);
      end
    end
  endtask

  task automatic test_random();
    model_t m, mc;
    logic [8:0] e_chr, c_chr;
    logic [1:0] e_rdy, c_rdy, acc, ci_acc;
    do_reset();
    m  = '{align_left: ALIGN, in_pkt: 1'b0, eop_pend: 1'b0, owner: 1, since: 0};
    mc = m;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(0, 7) == 0) push_pkt(ch, 1'b0);
        if ($urandom_range(0, 7) == 0) push_pkt(ch, 1'b1);
      end
      if (src0.size() > 30) src0.delete();
      vmask = {$urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0};
      tx_en = ($urandom_range(0, 9) != 0);
      drive_inputs();
      #1;
      model_step(m, CI_MAIN, tx_en, ch_valid, ch_data, ch_last, e_chr, e_rdy);
      model_step(mc, CI_SHORT, tx_en, ci_valid, ci_data, ci_last, c_chr, c_rdy);
      n_checks++;
      if (ch_ready !== e_rdy) begin
        n_errors++; $display("FAIL rand_ready@%0d: got %b expected %b", cyc, ch_ready, e_rdy);
      end
      n_checks++;
      if (ci_ready !== c_rdy) begin
        n_errors++; $display("FAIL rand_ci_ready@%0d: got %b expected %b", cyc, ci_ready, c_rdy);
      end
      acc    = ch_valid & ch_ready;
      ci_acc = ci_valid & ci_ready;
      @(posedge clk);
      pop_accepted(acc, ci_acc);
      #1;
      n_checks++;
      if ({tx_k, tx_data} !== e_chr) begin
        n_errors++; $display("FAIL rand_char@%0d: got %h expected %h", cyc, {tx_k, tx_data}, e_chr);
      end
      n_checks++;
      if ({ci_tx_k, ci_tx_data} !== c_chr) begin
        n_errors++; $display("FAIL rand_ci_char@%0d: got %h expected %h", cyc, {ci_tx_k, ci_tx_data}, c_chr);
      end
      n_checks++;
      if (grant !== 1'(m.owner) || busy !== (m.in_pkt || m.eop_pend)) begin
        n_errors++; $display("FAIL rand_grant_busy@%0d: got %b/%b expected %0d/%b", cyc, grant, busy, m.owner, m.in_pkt || m.eop_pend);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_comma_insert();
    test_underflow();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
